// File: rtl/food_pkg.sv
// Shared constants for the food generator, tracker and renderer.
// Latency: n/a (package only).
// Backpressure: n/a.
package food_pkg;

  localparam int MAZE_W = 10;
  localparam int MAZE_H = 15;
  localparam int CELLS  = 150;

  localparam logic [1:0] FOOD_NONE   = 2'b00;
  localparam logic [1:0] FOOD_NORMAL = 2'b01;
  localparam logic [1:0] FOOD_RARE   = 2'b10;
  localparam logic [1:0] FOOD_CRUX   = 2'b11;

  localparam int DEF_SCORE_W    = 16;
  localparam int DEF_NORMAL_PTS = 1;
  localparam int DEF_RARE_PTS   = 5;
  localparam int DEF_CRUX_PTS   = 10;

  typedef enum logic [1:0] {
    WAIT_GEN = 2'd0,
    SCAN     = 2'd1,
    PLAY     = 2'd2
  } state_t;

endpackage

// File: rtl/food_cell_index.sv
// Maps a maze coordinate to a linear cell index and flags out-of-maze points.
// Latency: combinational.
// Backpressure: none.
module food_cell_index
  import food_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] idx,
  output logic       valid
);

  // Row-major index in 8 bits; only meaningful when valid is high.
  assign idx   = ({4'b0, y} * 8'd10) + {4'b0, x};
  assign valid = (x < 4'(MAZE_W)) && (y < 4'(MAZE_H));

endmodule

// File: rtl/food_tracker.sv
// Snapshots the generator map, counts items, then serves eat requests and scoring.
// Latency: eat result 1 cycle after acceptance; read port 1 cycle.
// Backpressure: eat_ready low outside PLAY and whenever restart is asserted.
module food_tracker
  import food_pkg::*;
#(
  parameter int SCORE_W    = DEF_SCORE_W,
  parameter int NORMAL_PTS = DEF_NORMAL_PTS,
  parameter int RARE_PTS   = DEF_RARE_PTS,
  parameter int CRUX_PTS   = DEF_CRUX_PTS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               gen_busy,
  input  logic [299:0]       food_in,
  input  logic               restart,
  input  logic               eat_valid,
  output logic               eat_ready,
  input  logic [3:0]         eat_x,
  input  logic [3:0]         eat_y,
  output logic               eat_done,
  output logic [1:0]         eat_kind,
  input  logic [3:0]         rd_x,
  input  logic [3:0]         rd_y,
  output logic [1:0]         rd_kind,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         food_left,
  output logic [2:0]         crux_left,
  output logic               level_done
);

  state_t state, state_nxt;
  logic [CELLS-1:0][1:0] map_q;
  logic [7:0] scan_cnt;
  logic [7:0] eat_idx, rd_idx, eat_sel, rd_sel;
  logic       eat_ok, rd_ok, accept;
  logic [1:0] eat_cell, scan_cell;
  logic [SCORE_W:0] pts, sum;
  logic [SCORE_W-1:0] score_nxt;

  food_cell_index u_eat_idx (.x(eat_x), .y(eat_y), .idx(eat_idx), .valid(eat_ok));
  food_cell_index u_rd_idx  (.x(rd_x),  .y(rd_y),  .idx(rd_idx),  .valid(rd_ok));

  // Invalid coordinates are steered to cell 0 so the map is never indexed out of range.
  assign eat_sel   = eat_ok ? eat_idx : 8'd0;
  assign rd_sel    = rd_ok  ? rd_idx  : 8'd0;
  assign eat_cell  = eat_ok ? map_q[eat_sel] : FOOD_NONE;
  assign scan_cell = map_q[scan_cnt];
  assign eat_ready = (state == PLAY) & ~restart;
  assign accept    = eat_valid & eat_ready;

  // Points for the eaten kind and the saturating score sum.
  always_comb begin
    pts = '0;
    case (eat_cell)
      FOOD_NORMAL: pts = (SCORE_W+1)'(NORMAL_PTS);
      FOOD_RARE:   pts = (SCORE_W+1)'(RARE_PTS);
      FOOD_CRUX:   pts = (SCORE_W+1)'(CRUX_PTS);
      default:     pts = '0;
    endcase
    sum       = {1'b0, score} + pts;
    score_nxt = sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= WAIT_GEN;
    else      state <= state_nxt;
  end

  // Next-state logic; restart overrides every state.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_GEN: if (!gen_busy) state_nxt = SCAN;
      SCAN:     if (scan_cnt == 8'(CELLS-1)) state_nxt = PLAY;
      PLAY:     state_nxt = PLAY;
      default:  state_nxt = WAIT_GEN;
    endcase
    if (restart) state_nxt = WAIT_GEN;
  end

  // Map, counters and score; score survives restart, only rst clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      map_q     <= '0;
      scan_cnt  <= '0;
      food_left <= '0;
      crux_left <= '0;
      score     <= '0;
    end else if (restart) begin
      map_q     <= '0;
      scan_cnt  <= '0;
      food_left <= '0;
      crux_left <= '0;
    end else if (state == WAIT_GEN) begin
      if (!gen_busy) begin
        map_q     <= food_in;
        scan_cnt  <= '0;
        food_left <= '0;
        crux_left <= '0;
      end
    end else if (state == SCAN) begin
      scan_cnt <= scan_cnt + 8'd1;
      if (scan_cell != FOOD_NONE) food_left <= food_left + 8'd1;
      if (scan_cell == FOOD_CRUX) crux_left <= crux_left + 3'd1;
    end else if (accept) begin
      if (eat_ok) map_q[eat_sel] <= FOOD_NONE;
      if (eat_cell != FOOD_NONE) food_left <= food_left - 8'd1;
      if (eat_cell == FOOD_CRUX) crux_left <= crux_left - 3'd1;
      score <= score_nxt;
    end
  end

  // Registered eat response, level flag and renderer read port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eat_done   <= 1'b0;
      eat_kind   <= FOOD_NONE;
      level_done <= 1'b0;
      rd_kind    <= FOOD_NONE;
    end else begin
      eat_done   <= accept;
      eat_kind   <= accept ? eat_cell : FOOD_NONE;
      level_done <= (state == PLAY) & (crux_left == 3'd0) & ~restart;
      rd_kind    <= rd_ok ? map_q[rd_sel] : FOOD_NONE;
    end
  end

endmodule

// File: doc/food_tracker.md
Name: food_tracker

Overview:
- Downstream consumer of the food generator.
- Once the generator deasserts busy, it snapshots the 300-bit food map, scans it to count the remaining items, then serves player "eat" requests.
- On each eat it clears the cell, updates a saturating score and the item counters, and raises level_done when every crux item is collected.
- Provides a one-cycle-latency read port so the renderer can draw the tracker's live map.

Parameters:
- SCORE_W, 16, score width in bits.
- NORMAL_PTS, 1, points for normal food (kind 01).
- RARE_PTS, 5, points for rare food (kind 10).
- CRUX_PTS, 10, points for crux food (kind 11).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- gen_busy  in  1  generator busy flag
- food_in  in  300  generator map; cell i occupies bits {i,1}{i,0}
- restart  in  1  level restart pulse; the top level resets the generator in the same cycle
- eat_valid  in  1  eat request
- eat_ready  out  1  combinational: (state==PLAY) & ~restart
- eat_x  in  4  player column, 0..9
- eat_y  in  4  player row, 0..14
- eat_done  out  1  one-cycle pulse, one cycle after an accepted eat
- eat_kind  out  2  cell content before the eat; valid with eat_done
- rd_x  in  4  renderer column
- rd_y  in  4  renderer row
- rd_kind  out  2  registered map content, 1-cycle latency
- score  out  SCORE_W  accumulated score
- food_left  out  8  non-empty cells remaining
- crux_left  out  3  crux cells remaining
- level_done  out  1  high in PLAY when crux_left==0

Behaviour:
- Cell encoding: 00 empty, 01 normal, 10 rare, 11 crux. Cell index = y*10+x, computed in 8 bits.
- A coordinate is valid iff x<10 and y<15.
- Reset (rst=0, asynchronous):
  - state=WAIT_GEN
  - local map, score, food_left, crux_left = 0
  - eat_done, eat_kind, rd_kind, level_done = 0
- WAIT_GEN: on the first cycle with gen_busy==0, latch food_in into the local map and go to SCAN.
- SCAN:
  - An 8-bit counter steps 0..149, one cell per cycle.
  - Each non-empty cell increments food_left; each 11 cell increments crux_left.
  - After cell 149 is counted, go to PLAY. SCAN takes exactly 150 cycles.
  - Overlapping crux placements are counted once, because counts come from the map, not from a constant 4.
- PLAY: an accepted eat is eat_valid & eat_ready. Next cycle:
  - eat_done=1 and eat_kind=old cell content.
  - The cell is set to 00.
  - score += points for the kind, saturating at 2^SCORE_W-1.
  - food_left decrements if kind!=00.
  - crux_left decrements if kind==11.
  - Eating an empty cell pulses eat_done with kind 00 and changes nothing.
  - An invalid coordinate pulses eat_done with kind 00 and writes nothing.
  - Back-to-back eats are accepted every cycle.
- level_done = (state==PLAY) & (crux_left==0). It is registered, so it rises the cycle after the final crux decrement.
- Restart, from any state:
  - Go to WAIT_GEN next cycle.
  - Clear map, food_left, crux_left, level_done and the SCAN counter.
  - score is retained; only rst clears it.
  - An eat in the same cycle is not accepted.
  - restart during SCAN aborts the scan.
- Read port:
  - rd_kind <= map[idx(rd_x,rd_y)] every cycle, in all states. Returns 00 for an invalid coordinate or an unloaded map.
  - If a read and an eat address the same cell in the same cycle, the read returns the pre-eat value.
- Counters never underflow: they are decremented only for kinds actually present in the map.

Decomposition:
- Shared package food_pkg:
  - MAZE_W=10, MAZE_H=15, CELLS=150
  - FOOD_NONE=2'b00, FOOD_NORMAL=2'b01, FOOD_RARE=2'b10, FOOD_CRUX=2'b11
  - State encoding WAIT_GEN/SCAN/PLAY
  - Point defaults
  - These are shared with the generator and renderer.
- Sub-module food_cell_index:
  - Combinational (x,y) -> 8-bit idx plus valid flag.
  - Instantiated twice, once for the eat port and once for the read port.

Test Plan:
1. Map with cell 0=01, cell 12=10, cells 45 and 120=11, all others 00; gen_busy 1->0 -> exactly 150 SCAN cycles; in PLAY, food_left=4, crux_left=2, level_done=0.
2. Eat (2,1) on the rare cell -> one cycle later eat_done=1, eat_kind=10, score=5, food_left=3; eating (2,1) again -> eat_kind=00 and score stays 5.
3. Eat (5,4) then (0,12) on consecutive cycles -> eat_kind 11 then 11, score=25, crux_left=0; level_done=1 on the following cycle.
4. Eat at (10,3) and at (0,15) -> eat_done with kind 00; counters and map unchanged; rd_kind at (10,3)=00.
5. In the same cycle, read (0,0) and eat (0,0) -> rd_kind=01; a read of (0,0) on the next cycle returns 00.
6. restart mid-SCAN at cell 70 -> WAIT_GEN, counters 0, score retained. rst low mid-PLAY -> all outputs 0 immediately, without waiting for a clock edge. SCORE_W=4 with repeated crux eats -> score saturates at 15.
